// File: rtl/qspi_pkg.sv
// qspi_pkg: shared state encoding, opcodes and edge-polarity helpers for the QSPI target
package qspi_pkg;
  localparam int NIBBLE_W = 4;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h38;
  localparam logic [7:0] CMD_READ_DEF = 8'h6B;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DUMMY, ST_WRITE, ST_READ, ST_IGNORE} qspi_tgt_state_t;
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction
  function automatic logic shift_on_rise(input logic cpol, input logic cpha);
    return cpol != cpha;
  endfunction
endpackage

// File: rtl/qspi_target_if.sv
// qspi_target_if: local register-port side of the QSPI target
interface qspi_target_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] rx_data, tx_data;
  logic rx_valid, tx_load, busy, cmd_err;
  modport slave (output rx_data, rx_valid, tx_load, busy, cmd_err, input tx_data);
  modport master (input rx_data, rx_valid, tx_load, busy, cmd_err, output tx_data);
endinterface

// File: rtl/qspi_sync.sv
// qspi_sync: 2-flop synchronizer with registered rising/falling edge strobes
module qspi_sync #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] meta_q, sync_q, prev_q, rise_q, fall_q;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end
  assign q_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/qspi_target.sv
// qspi_target: oversampled quad-SPI target decoding write/read commands on sys_clk
module qspi_target import qspi_pkg::*; #(
  parameter bit CPOL = 1'b1,
  parameter bit CPHA = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter int DUMMY_CYCLES = 2,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic sck_in,
  input  logic csb_in,
  inout  wire  IO_0,
  inout  wire  IO_1,
  inout  wire  IO_2,
  inout  wire  IO_3,
  qspi_target_if.slave bus
);
  localparam int NIB = DATA_WIDTH / NIBBLE_W;
  localparam int TOP = DATA_WIDTH - 1;
  // with CPHA=0 the trailing edge of the last command cycle is not a turnaround cycle
  localparam int DUMMY_WAIT = DUMMY_CYCLES + (CPHA ? 0 : 1);
  localparam int CW = $clog2(NIB + DUMMY_CYCLES + 2);
  localparam logic SMP_R = sample_on_rise(CPOL, CPHA);
  localparam logic SHF_R = shift_on_rise(CPOL, CPHA);
  qspi_tgt_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NIBBLE_W-1:0] cmd_q, cmd_d, io_q, io_d, io_s;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, word;
  logic rx_valid_q, rx_valid_d, oe_q, oe_d, ld, err;
  logic [1:0] ctl_s, ctl_rise, ctl_fall;
  logic sample_edge, shift_edge;
  logic [7:0] op;
  qspi_sync #(.W(2), .RST_VAL({1'b1, CPOL})) u_sync_ctl (
    .sys_clk(sys_clk), .rst_n(rst_n), .d_i({csb_in, sck_in}),
    .q_o(ctl_s), .rise_o(ctl_rise), .fall_o(ctl_fall)
  );
  qspi_sync #(.W(4)) u_sync_io (
    .sys_clk(sys_clk), .rst_n(rst_n), .d_i({IO_3, IO_2, IO_1, IO_0}),
    .q_o(io_s), .rise_o(), .fall_o()
  );
  assign sample_edge = SMP_R ? ctl_rise[0] : ctl_fall[0];
  assign shift_edge = SHF_R ? ctl_rise[0] : ctl_fall[0];
  assign op = {cmd_q, io_s};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    io_d = io_q;
    oe_d = oe_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    tx_sh_d = tx_sh_q;
    word = tx_sh_q;
    ld = 1'b0;
    err = 1'b0;
    if (ctl_rise[1]) begin
      state_d = ST_IDLE;
      oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (ctl_fall[1]) begin
          state_d = ST_CMD;
          cnt_d = '0;
        end
        ST_CMD: if (sample_edge) begin
          cmd_d = io_s;
          cnt_d = CW'(1);
          if (cnt_q != '0) begin
            cnt_d = '0;
            ld = op == CMD_READ;
            state_d = (op == CMD_WRITE) ? ST_WRITE : ld ? ((DUMMY_WAIT == 0) ? ST_READ : ST_DUMMY) : ST_IGNORE;
            err = state_d == ST_IGNORE;
            oe_d = state_d == ST_READ;
            tx_sh_d = ld ? bus.tx_data : tx_sh_q;
          end
        end
        ST_DUMMY: if (shift_edge) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DUMMY_WAIT - 1)) begin
            state_d = ST_READ;
            oe_d = 1'b1;
            cnt_d = CPHA ? '0 : CW'(1);
            io_d = CPHA ? io_q : tx_sh_q[TOP -: NIBBLE_W];
            tx_sh_d = CPHA ? tx_sh_q : tx_sh_q << NIBBLE_W;
          end
        end
        ST_READ: if (shift_edge) begin
          ld = cnt_q == CW'(NIB);
          word = ld ? bus.tx_data : tx_sh_q;
          io_d = word[TOP -: NIBBLE_W];
          tx_sh_d = word << NIBBLE_W;
          cnt_d = ld ? CW'(1) : cnt_q + 1'b1;
        end
        ST_WRITE: if (sample_edge) begin
          rx_sh_d = (rx_sh_q << NIBBLE_W) | DATA_WIDTH'(io_s);
          rx_valid_d = cnt_q == CW'(NIB - 1);
          rx_data_d = rx_valid_d ? rx_sh_d : rx_data_q;
          cnt_d = rx_valid_d ? '0 : cnt_q + 1'b1;
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      cmd_q <= '0;
      io_q <= '0;
      oe_q <= 1'b0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      io_q <= io_d;
      oe_q <= oe_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q <= tx_sh_d;
    end
  end
  assign IO_0 = oe_q ? io_q[0] : 1'bz;
  assign IO_1 = oe_q ? io_q[1] : 1'bz;
  assign IO_2 = oe_q ? io_q[2] : 1'bz;
  assign IO_3 = oe_q ? io_q[3] : 1'bz;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load = ld;
  assign bus.cmd_err = err;
  assign bus.busy = ~ctl_s[1];
endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: directed mode-2 QSPI master driving writes, reads, bad opcodes, aborts and reset
module tb_qspi_target;
  logic sys_clk = 1'b0, rst_n = 1'b0, sck = 1'b1, csb = 1'b1, tb_oe = 1'b1;
  logic [3:0] tb_io = 4'h6;
  logic [3:0] r;
  wire IO_0, IO_1, IO_2, IO_3;
  logic [3:0] io_bus;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_rxv = 0, n_txl = 0, n_err = 0, n_both = 0;
  int b_rxv, b_txl, b_err;
  qspi_target_if #(.DATA_WIDTH(8)) bus ();
  qspi_target dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sck_in(sck), .csb_in(csb),
    .IO_0(IO_0), .IO_1(IO_1), .IO_2(IO_2), .IO_3(IO_3), .bus(bus)
  );
  assign IO_0 = tb_oe ? tb_io[0] : 1'bz;
  assign IO_1 = tb_oe ? tb_io[1] : 1'bz;
  assign IO_2 = tb_oe ? tb_io[2] : 1'bz;
  assign IO_3 = tb_oe ? tb_io[3] : 1'bz;
  assign io_bus = {IO_3, IO_2, IO_1, IO_0};
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    if (bus.rx_valid) n_rxv <= n_rxv + 1;
    if (bus.tx_load) n_txl <= n_txl + 1;
    if (bus.cmd_err) n_err <= n_err + 1;
    if (bus.rx_valid && bus.tx_load) n_both <= n_both + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic half();
    repeat (5) @(negedge sys_clk);
  endtask
  task automatic snap();
    b_rxv = n_rxv;
    b_txl = n_txl;
    b_err = n_err;
  endtask
  task automatic cs_low();
    csb = 1'b0;
    half();
  endtask
  task automatic cs_high();
    csb = 1'b1;
    half();
    half();
  endtask
  task automatic nib_out(input logic [3:0] n);
    tb_oe = 1'b1;
    tb_io = n;
    half();
    sck = 1'b0;
    half();
    sck = 1'b1;
  endtask
  task automatic cmd(input logic [7:0] op);
    nib_out(op[7:4]);
    nib_out(op[3:0]);
  endtask
  task automatic dummy_cyc(input string tag);
    tb_oe = 1'b1;
    tb_io = 4'h6;
    half();
    check(tag, io_bus, 4'h6);
    sck = 1'b0;
    half();
    sck = 1'b1;
  endtask
  task automatic nib_in(input bit last, output logic [3:0] n);
    tb_oe = 1'b0;
    half();
    n = io_bus;
    sck = 1'b0;
    half();
    if (last) begin
      csb = 1'b1;
      half();
    end
    sck = 1'b1;
  endtask
  initial begin
    bus.tx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_tx_load", bus.tx_load, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_err", bus.cmd_err, 1'b0);
    check("rst_io_hiz", io_bus, 4'h6);
    rst_n = 1'b1;
    half();
    // write 8'hA5, with exact rx_valid latency on the final nibble
    snap();
    cs_low();
    check("wr_busy_start", bus.busy, 1'b1);
    cmd(8'h38);
    nib_out(4'hA);
    tb_io = 4'h5;
    half();
    sck = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("wr_rxv_lat3", bus.rx_valid, 1'b0);
    @(negedge sys_clk);
    check("wr_rxv_lat4", bus.rx_valid, 1'b1);
    check("wr_rx_data", bus.rx_data, 8'hA5);
    @(negedge sys_clk);
    check("wr_rxv_one_cycle", bus.rx_valid, 1'b0);
    repeat (3) @(negedge sys_clk);
    sck = 1'b1;
    half();
    check("wr_busy_mid", bus.busy, 1'b1);
    cs_high();
    check("wr_busy_end", bus.busy, 1'b0);
    check("wr_rxv_count", n_rxv - b_rxv, 1);
    check("wr_no_txl", n_txl - b_txl, 0);
    // single-word read of 8'h3C; tx_data changed after decode must not leak in
    bus.tx_data = 8'h3C;
    snap();
    cs_low();
    cmd(8'h6B);
    check("rd_txl_decode", n_txl - b_txl, 1);
    bus.tx_data = 8'hFF;
    dummy_cyc("rd_dummy1_hiz");
    dummy_cyc("rd_dummy2_hiz");
    nib_in(1'b0, r);
    check("rd_nib0", r, 4'h3);
    nib_in(1'b1, r);
    check("rd_nib1", r, 4'hC);
    half();
    check("rd_txl_total", n_txl - b_txl, 1);
    check("rd_no_err", n_err - b_err, 0);
    check("rd_busy_end", bus.busy, 1'b0);
    // streaming read 8'h12 then 8'h34
    bus.tx_data = 8'h12;
    snap();
    cs_low();
    cmd(8'h6B);
    bus.tx_data = 8'h34;
    dummy_cyc("st_dummy1_hiz");
    dummy_cyc("st_dummy2_hiz");
    nib_in(1'b0, r);
    check("st_nib0", r, 4'h1);
    nib_in(1'b0, r);
    check("st_nib1", r, 4'h2);
    nib_in(1'b0, r);
    check("st_nib2", r, 4'h3);
    check("st_txl_reload", n_txl - b_txl, 2);
    nib_in(1'b1, r);
    check("st_nib3", r, 4'h4);
    half();
    check("st_txl_total", n_txl - b_txl, 2);
    // unknown opcode 8'h9F
    snap();
    cs_low();
    cmd(8'h9F);
    check("bad_cmd_err", n_err - b_err, 1);
    nib_out(4'h1);
    nib_out(4'h2);
    nib_out(4'h3);
    nib_out(4'h4);
    dummy_cyc("bad_io_hiz");
    cs_high();
    check("bad_cmd_err_once", n_err - b_err, 1);
    check("bad_no_rxv", n_rxv - b_rxv, 0);
    check("bad_no_txl", n_txl - b_txl, 0);
    // abort a partial write, then a clean write of 8'h5A
    snap();
    cs_low();
    cmd(8'h38);
    nib_out(4'h7);
    cs_high();
    check("abort_no_rxv", n_rxv - b_rxv, 0);
    cs_low();
    cmd(8'h38);
    nib_out(4'h5);
    nib_out(4'hA);
    cs_high();
    check("abort_rxv_count", n_rxv - b_rxv, 1);
    check("abort_rx_data", bus.rx_data, 8'h5A);
    // csb rise coinciding with the final sample edge wins
    snap();
    cs_low();
    cmd(8'h38);
    nib_out(4'hC);
    tb_io = 4'h3;
    half();
    sck = 1'b0;
    csb = 1'b1;
    half();
    sck = 1'b1;
    half();
    half();
    check("race_no_rxv", n_rxv - b_rxv, 0);
    check("race_rx_data", bus.rx_data, 8'h5A);
    // asynchronous reset while the target drives IO in READ
    bus.tx_data = 8'h3C;
    cs_low();
    cmd(8'h6B);
    dummy_cyc("rr_dummy1_hiz");
    dummy_cyc("rr_dummy2_hiz");
    nib_in(1'b0, r);
    check("rr_nib0", r, 4'h3);
    half();
    check("rr_driving", io_bus, 4'hC);
    rst_n = 1'b0;
    tb_oe = 1'b1;
    tb_io = 4'h6;
    #1;
    check("rr_io_hiz", io_bus, 4'h6);
    check("rr_rx_data", bus.rx_data, 8'h00);
    check("rr_rx_valid", bus.rx_valid, 1'b0);
    check("rr_tx_load", bus.tx_load, 1'b0);
    check("rr_busy", bus.busy, 1'b0);
    check("rr_cmd_err", bus.cmd_err, 1'b0);
    csb = 1'b1;
    half();
    rst_n = 1'b1;
    half();
    snap();
    cs_low();
    cmd(8'h38);
    nib_out(4'h9);
    nib_out(4'h6);
    cs_high();
    check("rr_after_rxv", n_rxv - b_rxv, 1);
    check("rr_after_data", bus.rx_data, 8'h96);
    check("never_both_strobes", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
